// File: rtl/psum_col_accum.sv
// Column-wise partial-sum accumulator feeding a 2-entry output buffer.
// Optional build macro PSUM_SAT_EN: clamp lane adds and raise sticky o_sat.
module psum_col_accum #(
    parameter int BIT_WIDTH     = 8,
    parameter int NO_COL_KERNEL = 5,
    parameter int ACC_WIDTH     = 2*BIT_WIDTH+4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_prod_valid,
    output logic                               o_prod_ready,
    input  logic [2*BIT_WIDTH*NO_COL_KERNEL-1:0] i_prod_col,
    input  logic [2:0]                         i_kercol,
    output logic                               o_sum_valid,
    input  logic                               i_sum_ready,
    output logic [ACC_WIDTH*NO_COL_KERNEL-1:0] o_sum_col,
    output logic [2:0]                         o_col_cnt,
    output logic                               o_busy,
    output logic                               o_seq_err,
    input  logic                               i_clr_err,
    output logic                               o_sat
);
    localparam int         PW       = 2*BIT_WIDTH;
    localparam logic [2:0] LAST_COL = 3'(NO_COL_KERNEL-1);
    localparam logic [2:0] NUM_COL  = 3'(NO_COL_KERNEL);

    typedef logic [NO_COL_KERNEL-1:0][ACC_WIDTH-1:0] lanes_t;
    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [2:0] col_cnt_q, col_cnt_d;
    lanes_t     acc_q, acc_d, ent0_q, ent0_d, ent1_q, ent1_d;
    lanes_t     lane_sum;
    logic [1:0] cnt_q, cnt_d;
    logic       seq_err_q, seq_err_d;
    logic       accept, pop, push, restart, in_range, is_last;

    assign restart  = (i_kercol == 3'd0);
    assign in_range = (i_kercol < NUM_COL);
    assign is_last  = (i_kercol == LAST_COL);

`ifdef PSUM_SAT_EN
    logic [NO_COL_KERNEL-1:0] lane_carry;
    logic sat_q, sat_d;
`endif

    // Column 0 always starts a fresh window, so its add ignores the accumulator.
    for (genvar i = 0; i < NO_COL_KERNEL; i++) begin : g_lane
        logic [ACC_WIDTH-1:0] prod_ext, base;
        assign prod_ext = ACC_WIDTH'(i_prod_col[i*PW +: PW]);
        assign base     = restart ? '0 : acc_q[i];
`ifdef PSUM_SAT_EN
        logic [ACC_WIDTH:0] full;
        assign full          = {1'b0, base} + {1'b0, prod_ext};
        assign lane_carry[i] = full[ACC_WIDTH];
        assign lane_sum[i]   = full[ACC_WIDTH] ? '1 : full[ACC_WIDTH-1:0];
`else
        assign lane_sum[i] = base + prod_ext;
`endif
    end

    // Ready ignores a same-cycle pop: no combinational path from i_sum_ready.
    assign o_prod_ready = (cnt_q != 2'd2);
    assign accept       = i_prod_valid && o_prod_ready;
    assign pop          = (cnt_q != 2'd0) && i_sum_ready;
    assign push         = accept && in_range && is_last;

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        acc_d     = acc_q;
        seq_err_d = seq_err_q;
        if (accept) begin
            if (!in_range) begin
                seq_err_d = 1'b1;
                col_cnt_d = 3'd0;
                acc_d     = '0;
                state_d   = IDLE;
            end else begin
                if (i_kercol != col_cnt_q) seq_err_d = 1'b1;
                if (is_last) begin
                    acc_d     = '0;
                    col_cnt_d = 3'd0;
                    state_d   = IDLE;
                end else begin
                    acc_d     = lane_sum;
                    col_cnt_d = i_kercol + 3'd1;
                    state_d   = ACCUM;
                end
            end
        end
        if (i_clr_err) seq_err_d = 1'b0;
    end

    // Push with a full buffer cannot happen, so push+pop implies one entry.
    always_comb begin
        cnt_d  = cnt_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) ent0_d = lane_sum;
                else               ent1_d = lane_sum;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: ent0_d = lane_sum;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            col_cnt_q <= 3'd0;
            acc_q     <= '0;
            ent0_q    <= '0;
            ent1_q    <= '0;
            cnt_q     <= 2'd0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            acc_q     <= acc_d;
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            cnt_q     <= cnt_d;
            seq_err_q <= seq_err_d;
        end
    end

`ifdef PSUM_SAT_EN
    always_comb begin
        sat_d = sat_q | (accept && in_range && (|lane_carry));
        if (i_clr_err) sat_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sat_q <= 1'b0;
        else          sat_q <= sat_d;
    end

    assign o_sat = sat_q;
`else
    assign o_sat = 1'b0;
`endif

    assign o_sum_valid = (cnt_q != 2'd0);
    assign o_sum_col   = ent0_q;
    assign o_col_cnt   = col_cnt_q;
    assign o_busy      = (state_q == ACCUM);
    assign o_seq_err   = seq_err_q;

endmodule
